// File: rtl/lab2_proc_muldiv_pkg.sv
// lab2_proc_muldiv_pkg: shared definitions for the iterative multiply/divide unit.
// Contents: fn encodings (MULDIV_*) and the control FSM state type.
// Optional feature macro used by the unit: LAB2_PROC_MULDIV_EARLY_OUT_EN.
package lab2_proc_muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL  = 3'd0;
  localparam logic [2:0] MULDIV_DIV  = 3'd1;
  localparam logic [2:0] MULDIV_DIVU = 3'd2;
  localparam logic [2:0] MULDIV_REM  = 3'd3;
  localparam logic [2:0] MULDIV_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/lab2_proc_muldiv_dpath.sv
// lab2_proc_muldiv_dpath: operand/accumulator registers, shift-add multiply step,
//   restoring divide step, sign correction and special-case result selection.
// Latency: one iteration per step_i cycle; result register updated on ld_i&spec_i or fin_i.
// Backpressure: none internally; res_o holds until the next load/finish.
// Ports: clk, reset (async active-high); ld_i/spec_i/step_i/fin_i from control;
//   fn_i, a_i, b_i request fields; res_o result; mul_zero_o (only with
//   LAB2_PROC_MULDIV_EARLY_OUT_EN) flags a MUL whose remaining multiplier is 0.
module lab2_proc_muldiv_dpath
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_i,
  input  logic               spec_i,
  input  logic               step_i,
  input  logic               fin_i,
  input  logic [2:0]         fn_i,
  input  logic [p_nbits-1:0] a_i,
  input  logic [p_nbits-1:0] b_i,
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
  output logic               mul_zero_o,
`endif
  output logic [p_nbits-1:0] res_o
);

  localparam int N = p_nbits;

  // a_q: multiplicand (MUL) or dividend shifting into quotient (divide).
  // b_q: multiplier (MUL) or divisor magnitude (divide).
  // acc_q: product accumulator (MUL) or partial remainder (divide).
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N:0]   acc_q, acc_d;
  logic [N-1:0] res_q;
  logic [2:0]   fn_q;
  logic         qneg_q, rneg_q;

  logic         signed_op, b_zero;
  logic [N-1:0] a_abs, b_abs, spec_res, fin_res, quo, rem;
  logic [N:0]   trial, diff;
  logic         ge;

  // Accept-time operand preparation and special-case result.
  always_comb begin
    signed_op = (fn_i == MULDIV_DIV) || (fn_i == MULDIV_REM);
    b_zero    = (b_i == '0);
    a_abs     = (signed_op && a_i[N-1]) ? -a_i : a_i;
    b_abs     = (signed_op && b_i[N-1]) ? -b_i : b_i;
    // For signed DIV/REM a special case with b != 0 can only be overflow.
    case (fn_i)
      MULDIV_DIV:  spec_res = b_zero ? '1 : a_i;
      MULDIV_DIVU: spec_res = '1;
      MULDIV_REM:  spec_res = b_zero ? a_i : '0;
      MULDIV_REMU: spec_res = a_i;
      default:     spec_res = '0;
    endcase
  end

  // One iteration of the selected algorithm.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    trial = {acc_q[N-1:0], a_q[N-1]};
    diff  = trial - {1'b0, b_q};
    ge    = ~diff[N];  // trial >= divisor: no borrow out of the top bit
    if (fn_q == MULDIV_MUL) begin
      acc_d = acc_q + {1'b0, a_q & {N{b_q[0]}}};
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end else begin
      acc_d = ge ? diff : trial;
      a_d   = {a_q[N-2:0], ge};
    end
  end

  // Final result is taken from the last iteration's next-state values.
  always_comb begin
    quo = qneg_q ? -a_d : a_d;
    rem = rneg_q ? -acc_d[N-1:0] : acc_d[N-1:0];
    case (fn_q)
      MULDIV_MUL:              fin_res = acc_d[N-1:0];
      MULDIV_DIV, MULDIV_DIVU: fin_res = quo;
      default:                 fin_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      fn_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (ld_i) begin
      fn_q   <= fn_i;
      qneg_q <= signed_op && (a_i[N-1] ^ b_i[N-1]);
      rneg_q <= signed_op && a_i[N-1];
      a_q    <= a_abs;
      b_q    <= b_abs;
      acc_q  <= '0;
      if (spec_i) res_q <= spec_res;
    end else if (step_i) begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      if (fin_i) res_q <= fin_res;
    end
  end

`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
  assign mul_zero_o = (fn_q == MULDIV_MUL) && (b_d == '0);
`endif

  assign res_o = res_q;

endmodule

// File: rtl/lab2_proc_muldiv_unit.sv
// lab2_proc_muldiv_unit: iterative MUL/DIV/DIVU/REM/REMU unit with kill, val/rdy both sides.
// Latency: p_nbits+1 cycles accept-to-valid (1 for special cases; MUL may finish early
//   when LAB2_PROC_MULDIV_EARLY_OUT_EN is defined). Backpressure: result held in DONE
//   until ostream_rdy; istream_rdy only in IDLE without kill. No overlap between ops.
// Ports: clk, reset (async active-high), kill; istream_{val,rdy,fn,a,b}; ostream_{val,rdy,msg}.
module lab2_proc_muldiv_unit
  import lab2_proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               kill,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_fn,
  input  logic [p_nbits-1:0] istream_a,
  input  logic [p_nbits-1:0] istream_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int             CW       = $clog2(p_nbits) + 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(p_nbits);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  muldiv_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic          val_q;

  logic accept, spec, step, last, fin;
  logic b_zero, a_min, b_ones, reserved, signed_div, mul_zero;

  // Handshake outputs depend on state and kill only.
  assign istream_rdy = (state_q == IDLE) && !kill && !reset;
  assign accept      = istream_val && istream_rdy;

  always_comb begin
    b_zero     = (istream_b == '0);
    a_min      = (istream_a == {1'b1, {(p_nbits-1){1'b0}}});
    b_ones     = (istream_b == '1);
    reserved   = (istream_fn > MULDIV_REMU);
    signed_div = (istream_fn == MULDIV_DIV) || (istream_fn == MULDIV_REM);
    spec       = reserved
               || ((istream_fn != MULDIV_MUL) && b_zero)
               || (signed_div && a_min && b_ones);
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
    spec       = spec || ((istream_fn == MULDIV_MUL) && b_zero);
`endif
  end

  assign step = (state_q == CALC) && !kill;
  assign last = (cnt_q == CNT_ONE) || mul_zero;
  assign fin  = step && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= 1'b0;
    end else if (kill) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (spec) begin
            state_q <= DONE;
            val_q   <= 1'b1;
          end else begin
            state_q <= CALC;
            cnt_q   <= CNT_INIT;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (last) begin
            state_q <= DONE;
            val_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        DONE: if (ostream_rdy) begin
          state_q <= IDLE;
          val_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ostream_val = val_q;

  lab2_proc_muldiv_dpath #(.p_nbits(p_nbits)) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .ld_i       (accept),
    .spec_i     (spec),
    .step_i     (step),
    .fin_i      (fin),
    .fn_i       (istream_fn),
    .a_i        (istream_a),
    .b_i        (istream_b),
`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
    .mul_zero_o (mul_zero),
`endif
    .res_o      (ostream_msg)
  );

`ifndef LAB2_PROC_MULDIV_EARLY_OUT_EN
  assign mul_zero = 1'b0;
`endif

endmodule

// File: tb/tb_lab2_proc_muldiv_unit.sv
// tb_lab2_proc_muldiv_unit: directed-vector bench for the multiply/divide unit (p_nbits = 32).
// Latency is counted from the accept cycle t; outputs are sampled on the falling edge.
// Expected MUL latencies follow LAB2_PROC_MULDIV_EARLY_OUT_EN when it is defined.
module tb_lab2_proc_muldiv_unit;
  import lab2_proc_muldiv_pkg::*;

`ifdef LAB2_PROC_MULDIV_EARLY_OUT_EN
  localparam int MUL_SMALL_LAT = 3;
  localparam int MUL_ZERO_LAT  = 1;
`else
  localparam int MUL_SMALL_LAT = 33;
  localparam int MUL_ZERO_LAT  = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, kill;
  logic        istream_val, istream_rdy;
  logic [2:0]  istream_fn;
  logic [31:0] istream_a, istream_b;
  logic        ostream_val, ostream_rdy;
  logic [31:0] ostream_msg;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lab2_proc_muldiv_unit #(.p_nbits(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .kill        (kill),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_fn  (istream_fn),
    .istream_a   (istream_a),
    .istream_b   (istream_b),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle t+1.
  task automatic issue(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    istream_val = 1'b1;
    istream_fn  = fn;
    istream_a   = a;
    istream_b   = b;
    check_eq({tag, " irdy"}, 32'(istream_rdy), 32'd1);
    @(posedge clk);
    #1 istream_val = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for ostream_val; checks latency from accept and the result.
  task automatic wait_val(input string tag, input int exp_lat, input logic [31:0] exp_msg);
    int k = 1;
    while (ostream_val !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, " lat"}, 32'(k), 32'(exp_lat));
    check_eq({tag, " msg"}, ostream_msg, exp_msg);
  endtask

  task automatic run(input string tag, input logic [2:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [31:0] exp_msg);
    issue(tag, fn, a, b);
    wait_val(tag, exp_lat, exp_msg);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int seen;
    reset       = 1'b1;
    kill        = 1'b0;
    istream_val = 1'b0;
    istream_fn  = '0;
    istream_a   = '0;
    istream_b   = '0;
    ostream_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset irdy", 32'(istream_rdy), 32'd0);
    check_eq("reset oval", 32'(ostream_val), 32'd0);
    check_eq("reset msg",  ostream_msg,      32'd0);
    reset = 1'b0;
    #1 check_eq("post-reset irdy", 32'(istream_rdy), 32'd1);
    @(negedge clk);

    run("mul 7*-3",   MULDIV_MUL,  32'd7,          32'hFFFFFFFD, 33,            32'hFFFFFFEB);
    run("mul 7*3",    MULDIV_MUL,  32'd7,          32'd3,        MUL_SMALL_LAT, 32'd21);
    run("mul x*0",    MULDIV_MUL,  32'd12345,      32'd0,        MUL_ZERO_LAT,  32'd0);
    run("div -7/2",   MULDIV_DIV,  32'hFFFFFFF9,   32'd2,        33,            32'hFFFFFFFD);
    run("rem -7%2",   MULDIV_REM,  32'hFFFFFFF9,   32'd2,        33,            32'hFFFFFFFF);
    run("divu big/2", MULDIV_DIVU, 32'hFFFFFFF9,   32'd2,        33,            32'h7FFFFFFC);
    run("div 7/-2",   MULDIV_DIV,  32'd7,          32'hFFFFFFFE, 33,            32'hFFFFFFFD);
    run("rem 7%-2",   MULDIV_REM,  32'd7,          32'hFFFFFFFE, 33,            32'd1);
    run("remu 100%7", MULDIV_REMU, 32'd100,        32'd7,        33,            32'd2);
    run("div 5/0",    MULDIV_DIV,  32'd5,          32'd0,        1,             32'hFFFFFFFF);
    run("rem 5%0",    MULDIV_REM,  32'd5,          32'd0,        1,             32'd5);
    run("divu 5/0",   MULDIV_DIVU, 32'd5,          32'd0,        1,             32'hFFFFFFFF);
    run("div ovf",    MULDIV_DIV,  32'h80000000,   32'hFFFFFFFF, 1,             32'h80000000);
    run("rem ovf",    MULDIV_REM,  32'h80000000,   32'hFFFFFFFF, 1,             32'd0);
    run("reserved",   3'd5,        32'd9,          32'd9,        1,             32'd0);

    // Backpressure: result must hold while ostream_rdy is low; a waiting request
    // is only accepted after the ready pulse.
    ostream_rdy = 1'b0;
    issue("bp", MULDIV_DIVU, 32'd100, 32'd7);
    wait_val("bp", 33, 32'd14);
    istream_val = 1'b1;
    istream_fn  = MULDIV_DIVU;
    istream_a   = 32'd200;
    istream_b   = 32'd7;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ostream_msg !== 32'd14 || ostream_val !== 1'b1 || istream_rdy !== 1'b0) bad++;
    end
    check_eq("bp hold", 32'(bad), 32'd0);
    ostream_rdy = 1'b1;
    @(posedge clk);
    #1 ostream_rdy = 1'b0;
    @(negedge clk);
    check_eq("bp released oval", 32'(ostream_val), 32'd0);
    check_eq("bp released irdy", 32'(istream_rdy), 32'd1);
    @(posedge clk);
    #1 begin
      istream_val = 1'b0;
      ostream_rdy = 1'b1;
    end
    @(negedge clk);
    wait_val("bp next", 33, 32'd28);
    @(negedge clk);

    // Kill during CALC: back to IDLE, no result ever appears.
    issue("kill", MULDIV_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check_eq("kill idle irdy", 32'(istream_rdy), 32'd1);
    check_eq("kill idle oval", 32'(ostream_val), 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ostream_val === 1'b1) seen++;
    end
    check_eq("kill no result", 32'(seen), 32'd0);

    // Request presented with kill high is not accepted; accepted one cycle later.
    istream_val = 1'b1;
    istream_fn  = MULDIV_REM;
    istream_a   = 32'hFFFFFF9C;
    istream_b   = 32'd7;
    kill        = 1'b1;
    #1 check_eq("kill blocks irdy", 32'(istream_rdy), 32'd0);
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check_eq("kill no accept oval", 32'(ostream_val), 32'd0);
    check_eq("kill retry irdy",     32'(istream_rdy), 32'd1);
    @(posedge clk);
    #1 istream_val = 1'b0;
    @(negedge clk);
    wait_val("rem -100%7", 33, 32'hFFFFFFFE);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
